// File: rtl/cen_gen_frac.sv
// Fractional clock-enable generator: NCH independent channels, each
// emitting one-cycle enable pulses at an average rate of clk_sys*num/den
// using a first-order accumulator (no drift over any den-cycle window).
module cen_gen_frac #(
  parameter int NCH     = 2,
  parameter int ACC_W   = 16,
  parameter int DEF_DEN = 20
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  input  logic [NCH-1:0]   ch_en,
  input  logic             pause,
  input  logic             sync,
  output logic [NCH-1:0]   cen,
  output logic [NCH-1:0]   cfg_err
);

  logic [ACC_W-1:0] num_q [NCH];
  logic [ACC_W-1:0] num_d [NCH];
  logic [ACC_W-1:0] den_q [NCH];
  logic [ACC_W-1:0] den_d [NCH];
  logic [ACC_W-1:0] acc_q [NCH];
  logic [ACC_W-1:0] acc_d [NCH];
  logic [NCH-1:0]   cen_q;
  logic [NCH-1:0]   cen_d;
  logic [NCH-1:0]   err_q;
  logic [NCH-1:0]   err_d;

  // A new configuration is invalid when it would ask for more than one
  // pulse per cycle or divide by zero; num==0 is legal and simply silent.
  logic cfgBad;
  assign cfgBad = (cfg_den == '0) || (cfg_num > cfg_den);

  // Per-channel next state: a config write to this channel wins, then sync,
  // then FAULT, HOLD and finally the RUN accumulator step.
  always_comb begin
    logic [ACC_W:0] sum;
    sum = '0;
    for (int i = 0; i < NCH; i++) begin
      num_d[i] = num_q[i];
      den_d[i] = den_q[i];
      acc_d[i] = acc_q[i];
      cen_d[i] = 1'b0;
      err_d[i] = err_q[i];
      sum      = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      if (cfg_we && (cfg_ch == 3'(i))) begin
        num_d[i] = cfg_num;
        den_d[i] = cfg_den;
        acc_d[i] = '0;
        err_d[i] = cfgBad;
      end else if (sync) begin
        acc_d[i] = '0;
      end else if (err_q[i]) begin
        acc_d[i] = '0;
      end else if (!ch_en[i] || pause) begin
        acc_d[i] = acc_q[i];
      end else if (sum >= {1'b0, den_q[i]}) begin
        acc_d[i] = ACC_W'(sum - {1'b0, den_q[i]});
        cen_d[i] = 1'b1;
      end else begin
        acc_d[i] = sum[ACC_W-1:0];
      end
    end
  end

  // Channel state registers; reset restores the default 1/DEF_DEN rate
  // with a cleared accumulator, which is equivalent to a fresh sync.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        num_q[i] <= ACC_W'(1);
        den_q[i] <= ACC_W'(DEF_DEN);
        acc_q[i] <= '0;
      end
      cen_q <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        num_q[i] <= num_d[i];
        den_q[i] <= den_d[i];
        acc_q[i] <= acc_d[i];
      end
      cen_q <= cen_d;
      err_q <= err_d;
    end
  end

  assign cen     = cen_q;
  assign cfg_err = err_q;

endmodule

// File: doc/cen_gen_frac.md
CEN_GEN_FRAC -- requirements
Module: cen_gen_frac

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 16, meaning width of numerator, denominator and accumulator (8..32).
REQ-003 SHALL have parameter DEF_DEN, default 20, meaning reset denominator of every channel (reset numerator is 1).
REQ-004 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cfg_we  input  1  one-cycle strobe writing cfg_num/cfg_den to channel cfg_ch.
REQ-007 SHALL have port cfg_ch  input  3  target channel; values >= NCH ignored.
REQ-008 SHALL have port cfg_num  input  ACC_W  rate numerator.
REQ-009 SHALL have port cfg_den  input  ACC_W  rate denominator.
REQ-010 SHALL have port ch_en  input  NCH  per-channel run enable.
REQ-011 SHALL have port pause  input  1  global freeze of all channels.
REQ-012 SHALL have port sync  input  1  one-cycle strobe realigning all channels.
REQ-013 SHALL have port cen  output  NCH  registered one-clk_sys-wide enable pulses, average rate clk_sys*num/den.
REQ-014 SHALL have port cfg_err  output  NCH  registered flag: channel configuration invalid.

Function
REQ-015 SHALL hold per channel registers num, den, acc (ACC_W bits each).
REQ-016 SHALL, per channel, be in one of states RUN (ch_en=1, pause=0, cfg_err=0), HOLD (ch_en=0 or pause=1), FAULT (cfg_err=1).
REQ-017 SHALL in RUN each edge compute sum=acc+num at ACC_W+1 bits; if sum>=den: acc<=sum-den, cen<=1; else acc<=sum, cen<=0.
REQ-018 SHALL in HOLD keep acc unchanged and drive cen<=0; return to RUN resumes from held acc with no lost or extra pulse.
REQ-019 SHALL in FAULT keep acc at 0 and drive cen<=0.
REQ-020 SHALL set cfg_err for a channel when den==0 or num>den, evaluated on the written values, registered same edge as the write.
REQ-021 SHALL with num==den produce cen=1 every cycle in RUN; num==0 produces no pulses (not a fault).
REQ-022 SHALL on cfg_we to a valid channel load num/den, clear that channel's acc and cen on the same edge; other channels unaffected.
REQ-023 SHALL on sync clear acc and cen of all channels on that edge; num/den retained.
REQ-024 SHALL with sync and cfg_we on the same edge apply both: all acc cleared, new config loaded.
REQ-025 SHALL with sync and pause on the same edge clear acc and remain held.
REQ-026 SHALL give first pulse after clear: cen high in the cycle following the k-th RUN edge, k = smallest integer with k*num>=den.
REQ-027 SHALL produce exactly num pulses per den RUN cycles over any aligned window (no drift).
REQ-028 SHALL ignore cfg_we when cfg_ch>=NCH (no state change).

Reset
REQ-029 SHALL on reset_n=0 asynchronously set all cen=0, cfg_err=0, acc=0, num=1, den=DEF_DEN.
REQ-030 SHALL after reset_n release with ch_en=1, pause=0 behave as if sync had just occurred.
REQ-031 SHALL on reset_n assertion mid-pulse drop cen within the same cycle (asynchronous).

Verification
REQ-032 Reset release, defaults, ch_en=all 1 -> cen[0] pulses every 20 cycles, first after 20 RUN edges.
REQ-033 cfg ch0 num=3 den=10 -> over 100 cycles exactly 30 pulses, spacing pattern 4,3,3 repeating.
REQ-034 cfg ch1 num=5 den=4 -> cfg_err[1]=1 next cycle, cen[1]=0; rewrite num=4 den=4 -> cfg_err[1]=0, cen[1]=1 every cycle.
REQ-035 num=1 den=4 running, pause high 7 cycles at acc=2 -> no pulses during pause; next pulse 2 RUN edges after release.
REQ-036 sync and cfg_we(ch0, num=1 den=2) same edge -> all acc=0; ch0 first pulse after 2 edges, ch1 restarts from 0.
REQ-037 reset_n low for 1 cycle while cen[0]=1 -> cen[0]=0 immediately; num/den return to 1/DEF_DEN.
